character_ctl: RTL

CHARACTER_CTL -- requirements
Module: character_ctl

---
 rtl/character_ctl.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/character_ctl.sv
// Character motion controller: jump arcs between block columns, falls to the floor on a miss.
// Define CHARACTER_CTL_JUMP_COUNT_EN to build the saturating successful-landing counter.
module character_ctl #(
    parameter int NCOLS       = 8,
    parameter int X_ORG       = 256,
    parameter int COL_STEP    = 64,
    parameter int START_COL   = 3,
    parameter int Y_REST      = 600,
    parameter int Y_FLOOR     = 767,
    parameter int JUMP_FRAMES = 16,
    parameter int V0          = 15,
    parameter int G           = 2,
    parameter int X_STEP      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic             restart,
    input  logic             jump_left,
    input  logic             jump_right,
    input  logic [NCOLS-1:0] block_map,
    output logic [10:0]      xpos,
    output logic [10:0]      ypos,
    output logic             character_landed,
    output logic             jump_fail,
    output logic [7:0]       jump_count
);

    localparam int CW = (NCOLS > 1) ? $clog2(NCOLS) : 1;
    localparam int FW = $clog2(JUMP_FRAMES + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARC  = 2'd1;
    localparam logic [1:0] ST_FALL = 2'd2;
    localparam logic [1:0] ST_DOWN = 2'd3;

    localparam logic [CW-1:0]      COL_START  = CW'(START_COL);
    localparam logic [CW-1:0]      COL_LAST   = CW'(NCOLS - 1);
    localparam logic [CW-1:0]      COL_ZERO   = CW'(0);
    localparam logic [CW-1:0]      COL_ONE    = CW'(1);
    localparam logic [10:0]        Y_REST_V   = 11'(Y_REST);
    localparam logic [10:0]        Y_FLOOR_V  = 11'(Y_FLOOR);
    localparam logic signed [11:0] Y_FLOOR_S  = 12'(Y_FLOOR);
    localparam logic [10:0]        X_STEP_V   = 11'(X_STEP);
    localparam logic signed [11:0] VY_INIT    = 12'(-V0);
    localparam logic signed [11:0] VY_ZERO    = 12'sd0;
    localparam logic signed [11:0] G_V        = 12'(G);
    localparam logic [FW-1:0]      FRAME_ZERO = FW'(0);
    localparam logic [FW-1:0]      FRAME_ONE  = FW'(1);
    localparam logic [FW-1:0]      FRAME_LAST = FW'(JUMP_FRAMES - 1);

    function automatic logic [10:0] col_x(input logic [CW-1:0] c);
        col_x = 11'(X_ORG + int'(c) * COL_STEP);
    endfunction

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [CW-1:0]     tgt_q, tgt_d;
    logic              ok_q, ok_d;
    logic              frz_q, frz_d;
    logic              dir_q, dir_d;
    logic signed [11:0] vy_q, vy_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic [10:0]       xpos_q, xpos_d;
    logic [10:0]       ypos_q, ypos_d;
    logic              landed_q, landed_d;
    logic              fail_q, fail_d;

    logic              req_s;
    logic              edge_s;
    logic [CW-1:0]     req_tgt_s;
    logic signed [11:0] ysum_s;
    logic [10:0]       xstep_s;

    // Request decode: simultaneous left/right cancel; an edge jump keeps the target on the current column.
    always_comb begin
        req_s  = jump_left ^ jump_right;
        edge_s = jump_right ? (col_q == COL_LAST) : (col_q == COL_ZERO);
        if (edge_s) begin
            req_tgt_s = col_q;
        end else if (jump_right) begin
            req_tgt_s = col_q + COL_ONE;
        end else begin
            req_tgt_s = col_q - COL_ONE;
        end
    end

    assign ysum_s  = $signed({1'b0, ypos_q}) + vy_q;
    assign xstep_s = dir_q ? (xpos_q + X_STEP_V) : (xpos_q - X_STEP_V);

    // Next-state and motion logic; restart overrides every state.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        tgt_d    = tgt_q;
        ok_d     = ok_q;
        frz_d    = frz_q;
        dir_d    = dir_q;
        vy_d     = vy_q;
        frame_d  = frame_q;
        xpos_d   = xpos_q;
        ypos_d   = ypos_q;
        landed_d = 1'b0;
        fail_d   = fail_q;
        if (restart) begin
            state_d = ST_IDLE;
            col_d   = COL_START;
            tgt_d   = COL_START;
            ok_d    = 1'b0;
            frz_d   = 1'b0;
            dir_d   = 1'b0;
            vy_d    = VY_ZERO;
            frame_d = FRAME_ZERO;
            xpos_d  = col_x(COL_START);
            ypos_d  = Y_REST_V;
            fail_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_s) begin
                        tgt_d   = req_tgt_s;
                        ok_d    = !edge_s && block_map[req_tgt_s];
                        frz_d   = edge_s;
                        dir_d   = jump_right;
                        vy_d    = VY_INIT;
                        frame_d = FRAME_ZERO;
                        state_d = ST_ARC;
                    end else begin
                        xpos_d = col_x(col_q);
                        ypos_d = Y_REST_V;
                    end
                end
                ST_ARC: begin
                    if (frame_tick) begin
                        frame_d = frame_q + FRAME_ONE;
                        vy_d    = vy_q + G_V;
                        // The final frame snaps to the exact rest position so rounding never accumulates.
                        if (frame_q == FRAME_LAST) begin
                            ypos_d   = Y_REST_V;
                            xpos_d   = frz_q ? xpos_q : col_x(tgt_q);
                            landed_d = 1'b1;
                            if (ok_q) begin
                                col_d   = tgt_q;
                                state_d = ST_IDLE;
                            end else begin
                                fail_d  = 1'b1;
                                state_d = ST_FALL;
                            end
                        end else begin
                            ypos_d = ysum_s[10:0];
                            xpos_d = frz_q ? xpos_q : xstep_s;
                        end
                    end else begin
                        frame_d = frame_q;
                    end
                end
                ST_FALL: begin
                    if (frame_tick) begin
                        vy_d = vy_q + G_V;
                        if (ysum_s >= Y_FLOOR_S) begin
                            ypos_d   = Y_FLOOR_V;
                            landed_d = 1'b1;
                            state_d  = ST_DOWN;
                        end else begin
                            ypos_d = ysum_s[10:0];
                        end
                    end else begin
                        vy_d = vy_q;
                    end
                end
                ST_DOWN: begin
                    state_d = ST_DOWN;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers, loaded with the restart position on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            col_q    <= COL_START;
            tgt_q    <= COL_START;
            ok_q     <= 1'b0;
            frz_q    <= 1'b0;
            dir_q    <= 1'b0;
            vy_q     <= VY_ZERO;
            frame_q  <= FRAME_ZERO;
            xpos_q   <= col_x(COL_START);
            ypos_q   <= Y_REST_V;
            landed_q <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            tgt_q    <= tgt_d;
            ok_q     <= ok_d;
            frz_q    <= frz_d;
            dir_q    <= dir_d;
            vy_q     <= vy_d;
            frame_q  <= frame_d;
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            landed_q <= landed_d;
            fail_q   <= fail_d;
        end
    end

    assign xpos             = xpos_q;
    assign ypos             = ypos_q;
    assign character_landed = landed_q;
    assign jump_fail        = fail_q;

`ifdef CHARACTER_CTL_JUMP_COUNT_EN
    logic       land_ok_s;
    logic [7:0] count_q, count_d;

    assign land_ok_s = (state_q == ST_ARC) && frame_tick && (frame_q == FRAME_LAST) && ok_q;

    // Saturating count of successful landings, cleared by restart.
    always_comb begin
        count_d = count_q;
        if (restart) begin
            count_d = 8'd0;
        end else if (land_ok_s && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Landing counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign jump_count = count_q;
`else
    assign jump_count = 8'd0;
`endif

endmodule
